// File: rtl/andor_stim.sv
// andor_stim: on-simulator stimulus/checker for the two-input, two-bit andor gate.
// Latency: busy and vector 0 appear 1 cycle after start. Each vector takes SETTLE+1 cycles.
//          done/pass appear 16*(SETTLE+1) cycles after the start edge.
// Backpressure: none. start is ignored while busy. A sync reset abandons the sweep.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start                    begin a sweep (honoured in IDLE or DONE)
//   monitor_m1, monitor_m2   DUT outputs, sampled combinationally at the CHECK edge
//   Input_i1, Input_i2       registered DUT operands (vec[3:2], vec[1:0])
//   busy, done, pass         sweep status
//   err_count                failing vectors in the last sweep (0..16)
//   fail_valid, fail_vec     first-failure capture, present only with ANDOR_STIM_FAILCAP_EN
// Parameter SETTLE (1..15): cycles each vector is held before it is checked.
module andor_stim #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       monitor_m1,
  input  logic       monitor_m2,
  output logic [1:0] Input_i1,
  output logic [1:0] Input_i2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count
`ifdef ANDOR_STIM_FAILCAP_EN
  ,
  output logic       fail_valid,
  output logic [3:0] fail_vec
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The settle counter runs 0..SETTLE-1 inside WAIT, so WAIT lasts SETTLE cycles.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       exp_m1, exp_m2, mismatch;
  logic       launch;

  assign Input_i1  = vec_q[3:2];
  assign Input_i2  = vec_q[1:0];
  assign busy      = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 5'd0);
  assign err_count = err_q;

  assign exp_m1   = Input_i1[0] & Input_i2[0];
  assign exp_m2   = Input_i1[1] & Input_i2[1];
  assign mismatch = (monitor_m1 != exp_m1) || (monitor_m2 != exp_m2);

  // A (re)start is honoured only from an idle or finished sweep.
  assign launch = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          state_d = S_WAIT;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
        end
        cnt_d = 4'd0;
        if (vec_q == 4'd15) begin
          // Vector 15 stays driven while in DONE.
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef ANDOR_STIM_FAILCAP_EN
  logic       fvld_q, fvld_d;
  logic [3:0] fvec_q, fvec_d;

  assign fail_valid = fvld_q;
  assign fail_vec   = fvec_q;

  // Only the first failing vector of a sweep is kept.
  always_comb begin
    fvld_d = fvld_q;
    fvec_d = fvec_q;
    if (launch) begin
      fvld_d = 1'b0;
      fvec_d = 4'd0;
    end else if ((state_q == S_CHECK) && mismatch && !fvld_q) begin
      fvld_d = 1'b1;
      fvec_d = vec_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fvld_q <= 1'b0;
      fvec_q <= 4'd0;
    end else begin
      fvld_q <= fvld_d;
      fvec_q <= fvec_d;
    end
  end
`endif

endmodule

// File: tb/tb_andor_stim.sv
// tb_andor_stim: drives two andor_stim instances (SETTLE=1 and SETTLE=3) against a
// behavioural andor gate that can be correct, have m1 stuck at 0, or have m1/m2 swapped.
// Table rows are run back to back, so each row after the first restarts from DONE.
module tb_andor_stim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel3 = 1'b0;   // 0: SETTLE=1 instance, 1: SETTLE=3 instance
  int   mode = 0;      // 0 correct, 1 m1 stuck at 0, 2 m1/m2 swapped

  always #5 clk = ~clk;

  logic [1:0] a1, b1, a3, b3;
  logic       m1_1, m2_1, m1_3, m2_3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] err1, err3;
  logic       start1, start3;
`ifdef ANDOR_STIM_FAILCAP_EN
  logic       fv1, fv3;
  logic [3:0] fvec1, fvec3;
`endif

  assign start1 = start & ~sel3;
  assign start3 = start & sel3;

  function automatic logic [1:0] gate(input int md, input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = a & b;
    if (md == 1) r[0] = 1'b0;
    else if (md == 2) r = {r[0], r[1]};
    return r;
  endfunction

  assign {m2_1, m1_1} = gate(mode, a1, b1);
  assign {m2_3, m1_3} = gate(mode, a3, b3);

  andor_stim #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .monitor_m1(m1_1), .monitor_m2(m2_1),
    .Input_i1(a1), .Input_i2(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef ANDOR_STIM_FAILCAP_EN
    , .fail_valid(fv1), .fail_vec(fvec1)
`endif
  );

  andor_stim #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .monitor_m1(m1_3), .monitor_m2(m2_3),
    .Input_i1(a3), .Input_i2(b3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef ANDOR_STIM_FAILCAP_EN
    , .fail_valid(fv3), .fail_vec(fvec3)
`endif
  );

  // Views of whichever instance is currently selected.
  logic       t_busy, t_done, t_pass;
  logic [4:0] t_err;
  logic [3:0] t_vec;
  always_comb begin
    t_busy = sel3 ? busy3 : busy1;
    t_done = sel3 ? done3 : done1;
    t_pass = sel3 ? pass3 : pass1;
    t_err  = sel3 ? err3 : err1;
    t_vec  = sel3 ? {a3, b3} : {a1, b1};
  end
`ifdef ANDOR_STIM_FAILCAP_EN
  logic       t_fv;
  logic [3:0] t_fvec;
  always_comb begin
    t_fv   = sel3 ? fv3 : fv1;
    t_fvec = sel3 ? fvec3 : fvec1;
  end
`endif

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    bit sel3;
    int repulse;    // cycle at which start is pulsed again mid-sweep (0 = never)
    int exp_err;
    int exp_pass;
    int exp_cyc;
    int exp_fvec;   // -1: no failure expected
  } row_t;

  // Start pulse: start is sampled at edge t; returns #1 after edge t.
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(input row_t v);
    int n, s1, hold_bad;
    mode = v.mode;
    sel3 = v.sel3;
    s1 = v.sel3 ? 4 : 2;
    pulse_start();
    chk("start_busy", int'(t_busy), 1);
    chk("start_done", int'(t_done), 0);
    chk("start_vec0", int'(t_vec), 0);
    chk("start_err_clear", int'(t_err), 0);
`ifdef ANDOR_STIM_FAILCAP_EN
    chk("start_fv_clear", int'(t_fv), 0);
`endif
    n = 0;
    hold_bad = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (t_done) break;
      start = (n == v.repulse);
      // Vector k is driven for exactly SETTLE+1 cycles after edge t.
      if (!t_busy || int'(t_vec) != n / s1) hold_bad++;
    end
    start = 1'b0;
    chk("done_cycle", n, v.exp_cyc);
    chk("hold_pattern_bad_cycles", hold_bad, 0);
    chk("done_busy_low", int'(t_busy), 0);
    chk("done_last_vec", int'(t_vec), 15);
    chk("err_count", int'(t_err), v.exp_err);
    chk("pass", int'(t_pass), v.exp_pass);
`ifdef ANDOR_STIM_FAILCAP_EN
    chk("fail_valid", int'(t_fv), (v.exp_fvec >= 0) ? 1 : 0);
    if (v.exp_fvec >= 0) chk("fail_vec", int'(t_fvec), v.exp_fvec);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, int'(t_busy), 0);
    chk({tag, "_done"}, int'(t_done), 0);
    chk({tag, "_pass"}, int'(t_pass), 0);
    chk({tag, "_err"}, int'(t_err), 0);
    chk({tag, "_vec"}, int'(t_vec), 0);
`ifdef ANDOR_STIM_FAILCAP_EN
    chk({tag, "_fv"}, int'(t_fv), 0);
    chk({tag, "_fvec"}, int'(t_fvec), 0);
`endif
  endtask

  row_t tbl[6];

  initial begin
    //           mode sel3 repulse err pass cyc fvec
    tbl[0] = '{0, 1'b0, 0,  0, 1, 32, -1};
    tbl[1] = '{1, 1'b0, 0,  4, 0, 32,  5};
    tbl[2] = '{2, 1'b0, 0,  6, 0, 32,  5};
    tbl[3] = '{0, 1'b1, 0,  0, 1, 64, -1};
    tbl[4] = '{0, 1'b0, 10, 0, 1, 32, -1};
    tbl[5] = '{1, 1'b1, 0,  4, 0, 64,  5};

    repeat (3) @(posedge clk);
    #1;
    sel3 = 1'b0;
    #1;
    chk_reset_state("rst1");
    sel3 = 1'b1;
    #1;
    chk_reset_state("rst3");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Reset mid-sweep with a stuck-at DUT: sweep abandoned, outputs back to reset.
    mode = 1;
    sel3 = 1'b0;
    pulse_start();
    repeat (12) @(posedge clk);
    #1;
    chk("midsweep_err_before_rst", int'(t_err), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state("midrst");
    run_sweep(tbl[1]);

    // rst and start on the same edge: reset wins, nothing starts.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk_reset_state("rst_vs_start");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vs_start_still_idle", int'(t_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
